// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Pure declarations; no logic, no latency, no backpressure.
package dmem_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int DMEM_WORDS = 1024;

  typedef struct packed {
    logic        we;
    logic        lock;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  // Word-aligned and inside the memory depth.
  function automatic logic addr_legal(input logic [31:0] addr, input int words);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < 32'(words));
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: first valid at or above ptr, wrapping modulo NREQ.
// Combinational, 0 cycles; no backpressure (grant is one-hot or zero).
module rr_pick #(
  parameter int  NREQ = 2,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  logic          found;
  int            j;
  logic [IW-1:0] jidx;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    jidx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      jidx = IW'(j);
      if (!found && valid[jidx]) begin
        grant[jidx] = 1'b1;
        idx         = jidx;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with lock in front of a single-port data memory.
// Grant 0 cycles, response 1 cycle later; losers see req_ready=0 and must hold.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int MEM_WORDS = DMEM_WORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_we,
  input  logic [NREQ-1:0]       req_lock,
  input  logic [NREQ-1:0][31:0] req_addr,
  input  logic [NREQ-1:0][31:0] req_wdata,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t      state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   gidx;
  dmem_req_t       sel;
  logic            xfer;
  logic            legal;

  // While locked only the owner may reach the picker.
  always_comb begin
    elig = req_valid;
    if (state_q == LOCKED) elig = req_valid & (NREQ'(1) << owner_q);
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .valid (elig),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .idx   (gidx)
  );

  always_comb begin
    req_ready   = rst ? '0 : grant;
    xfer        = |req_ready;
    sel         = {req_we[gidx], req_lock[gidx], req_addr[gidx], req_wdata[gidx]};
    legal       = addr_legal(sel.addr, MEM_WORDS);
    mem_we      = xfer & legal & sel.we;
    mem_re      = xfer & legal & ~sel.we;
    mem_addr    = (xfer && legal) ? sel.addr : '0;
    mem_wdata   = mem_we ? sel.wdata : '0;
    rsp_valid_d = req_ready;
    rsp_rdata_d = mem_re ? mem_rdata : '0;
    rsp_err_d   = xfer & ~legal;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    case (state_q)
      ARB: begin
        if (xfer) begin
          rr_ptr_d = (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
          if (sel.lock) begin
            state_d = LOCKED;
            owner_d = gidx;
          end
        end
      end
      LOCKED: begin
        if (!req_lock[owner_q]) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic against a
// behavioural model, with responses matched by a scoreboard monitor.
module tb_dmem_arbiter;

  localparam int NREQ      = 2;
  localparam int MEM_WORDS = 1024;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid, req_we, req_lock, req_ready, rsp_valid;
  logic [NREQ-1:0][31:0] req_addr, req_wdata;
  logic [31:0]           rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic                  rsp_err, mem_we, mem_re;

  logic [31:0] mem     [0:MEM_WORDS-1];
  logic [31:0] ref_mem [0:MEM_WORDS-1];

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;

  dmem_arbiter #(.NREQ(NREQ), .MEM_WORDS(MEM_WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  typedef struct {
    int          due;
    int          port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t            sb[$];
  int              total = 0;
  int              bad   = 0;
  int              cyc   = 0;
  int              m_rr  = 0;
  int              m_owner = 0;
  bit              m_locked = 1'b0;
  logic [NREQ-1:0] last_rdy = '0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit legal_f(input logic [31:0] a);
    return (a % 4 == 0) && (a / 4 < MEM_WORDS);
  endfunction

  // Reference: decide the winner from the rules, predict memory port and response.
  task automatic model_cycle();
    int          g = -1;
    int          w;
    bit          lg;
    exp_t        e;
    logic [31:0] a;
    logic        ewe, ere;
    logic [31:0] eaddr, ewd;
    if (!rst) begin
      if (m_locked) begin
        if (req_valid[m_owner]) g = m_owner;
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          int p = (m_rr + k) % NREQ;
          if (g < 0 && req_valid[p]) g = p;
        end
      end
    end
    chk("req_ready", 96'(req_ready), (g >= 0) ? (96'(1) << g) : 96'(0));
    ewe = 1'b0; ere = 1'b0; eaddr = '0; ewd = '0;
    if (g >= 0) begin
      a  = req_addr[g];
      lg = legal_f(a);
      w  = int'(a / 4);
      if (lg) begin
        eaddr = a;
        if (req_we[g]) begin
          ewe = 1'b1;
          ewd = req_wdata[g];
        end else begin
          ere = 1'b1;
        end
      end
      e.due   = cyc + 1;
      e.port  = g;
      e.err   = !lg;
      e.rdata = (lg && !req_we[g]) ? ref_mem[w] : 32'h0;
      sb.push_back(e);
      if (lg && req_we[g]) ref_mem[w] = req_wdata[g];
    end
    chk("mem_port", {mem_we, mem_re, mem_addr, mem_wdata}, {ewe, ere, eaddr, ewd});
    if (rst) begin
      m_rr = 0; m_locked = 1'b0; m_owner = 0;
    end else if (m_locked) begin
      if (!req_lock[m_owner]) m_locked = 1'b0;
    end else if (g >= 0) begin
      m_rr = (g + 1) % NREQ;
      if (req_lock[g]) begin
        m_locked = 1'b1;
        m_owner  = g;
      end
    end
  endtask

  task automatic step();
    #3;
    model_cycle();
    last_rdy = req_ready;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic put(input int p, input bit v, input bit we, input bit lk,
                     input logic [31:0] a, input logic [31:0] wd);
    req_valid[p] = v;
    req_we[p]    = we;
    req_lock[p]  = lk;
    req_addr[p]  = a;
    req_wdata[p] = wd;
  endtask

  task automatic idle();
    for (int p = 0; p < NREQ; p++) put(p, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'(1) << e.port, e.err, e.rdata});
      end else begin
        chk("rsp_quiet", 96'(rsp_valid), 96'(0));
      end
    end
  end

  initial begin : driver
    int          r;
    int          diff;
    logic [31:0] a;
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    rst = 1'b1;
    idle();
    put(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    put(1, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
    step();
    step();
    rst = 1'b0;
    step();

    idle();
    put(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    step();
    put(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    step();
    idle();
    put(1, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
    step();

    put(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    put(1, 1'b1, 1'b0, 1'b0, 32'h14, 32'h0);
    repeat (6) step();

    idle();
    put(0, 1'b1, 1'b0, 1'b0, 32'h30, 32'h0);
    step();
    put(1, 1'b1, 1'b0, 1'b1, 32'h20, 32'h0);
    step();
    put(1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h12345678);
    step();
    put(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    idle();
    put(1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    step();

    idle();
    put(0, 1'b1, 1'b0, 1'b0, 32'h1002, 32'h0);
    step();
    put(0, 1'b1, 1'b1, 1'b0, 32'h1000, 32'hCAFEF00D);
    step();
    put(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    idle();
    put(0, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0);
    step();
    rst = 1'b1;
    put(1, 1'b1, 1'b0, 1'b0, 32'h44, 32'h0);
    step();
    rst = 1'b0;
    step();
    idle();
    step();

    repeat (3000) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int p = 0; p < NREQ; p++) begin
        if (!(req_valid[p] && !last_rdy[p])) begin
          r = $urandom_range(0, 9);
          if (r < 7)       a = 32'($urandom_range(0, 15)) * 4;
          else if (r == 7) a = 32'($urandom_range(0, 63)) | 32'h1;
          else if (r == 8) a = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
          else             a = 32'hFFC;
          put(p, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 3) == 0, a, $urandom);
        end
      end
      step();
    end

    rst = 1'b0;
    idle();
    repeat (3) step();
    chk("scoreboard_drained", 96'(sb.size()), 96'(0));
    diff = 0;
    for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) diff++;
    chk("mem_image_words_differing", 96'(diff), 96'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
